// File: rtl/lvds_align_pkg.sv
// Shared definitions for the LVDS word aligner: lane FSM states and the
// default training word.
package lvds_align_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SLIP,
    WAIT,
    LOCKED,
    ERR
  } lane_state_t;

  localparam logic [7:0] DEFAULT_TRAIN_PATTERN = 8'h7E;

endpackage

// File: rtl/lvds_lane_aligner.sv
// Per-lane word alignment FSM: compares the lane word with the training
// pattern, issues bitslip pulses until it matches, then locks or errors out.
module lvds_lane_aligner
  import lvds_align_pkg::*;
#(
  parameter int unsigned       WIDTH         = 8,
  parameter logic [WIDTH-1:0]  TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int unsigned       MATCH_COUNT   = 8,
  parameter int unsigned       SLIP_WAIT     = 4,
  parameter int unsigned       MAX_SLIPS     = 2*WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] word,
  input  logic             train_en,
  input  logic             retrain,
  output logic             bitslip,
  output logic             lane_locked,
  output logic             lane_err
);

  localparam int unsigned MW = $clog2(MATCH_COUNT + 1);
  localparam int unsigned SW = $clog2(MAX_SLIPS + 1);
  localparam int unsigned WW = $clog2(SLIP_WAIT + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);
  localparam logic [SW-1:0] SLIP_LIMIT = SW'(MAX_SLIPS);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);

  lane_state_t   state, state_nxt;
  logic [MW-1:0] match_cnt, match_nxt;
  logic [SW-1:0] slip_cnt, slip_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      match_cnt <= '0;
      slip_cnt  <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      slip_cnt  <= slip_nxt;
      wait_cnt  <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    slip_nxt  = slip_cnt;
    wait_nxt  = wait_cnt;
    if (retrain) begin
      state_nxt = IDLE;
      match_nxt = '0;
      slip_nxt  = '0;
      wait_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          match_nxt = '0;
          slip_nxt  = '0;
          wait_nxt  = '0;
          if (train_en) state_nxt = CHECK;
        end
        CHECK: begin
          if (!train_en) begin
            state_nxt = IDLE;
          end else if (word == TRAIN_PATTERN) begin
            match_nxt = match_cnt + 1'b1;
            if (match_cnt == MATCH_LAST) state_nxt = LOCKED;
          end else begin
            match_nxt = '0;
            state_nxt = (slip_cnt < SLIP_LIMIT) ? SLIP : ERR;
          end
        end
        // The pulse always lasts one full cycle, even if training is dropped.
        SLIP: begin
          slip_nxt  = slip_cnt + 1'b1;
          wait_nxt  = '0;
          state_nxt = train_en ? WAIT : IDLE;
        end
        WAIT: begin
          if (!train_en) begin
            state_nxt = IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_nxt  = '0;
            state_nxt = CHECK;
          end else begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end
        LOCKED, ERR: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bitslip     = (state == SLIP);
  assign lane_locked = (state == LOCKED);
  assign lane_err    = (state == ERR);

endmodule

// File: rtl/lvds_word_aligner.sv
// Multi-lane LVDS word aligner: de-interleaves ISERDES output into lane
// words and runs one independent alignment FSM per lane.
module lvds_word_aligner
  import lvds_align_pkg::*;
#(
  parameter int unsigned      LANES         = 5,
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int unsigned      MATCH_COUNT   = 8,
  parameter int unsigned      SLIP_WAIT     = 4,
  parameter int unsigned      MAX_SLIPS     = 2*WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LANES*WIDTH-1:0] rxdin,
  input  logic                   train_en,
  input  logic                   retrain,
  output logic [LANES*WIDTH-1:0] rxdout,
  output logic [LANES-1:0]       bitslip,
  output logic [LANES-1:0]       lane_locked,
  output logic [LANES-1:0]       lane_err,
  output logic                   all_locked
);

  logic [LANES*WIDTH-1:0] lane_words;

  // ISERDES places lane l bit k at k*LANES+l; regroup so each lane is contiguous.
  always_comb begin
    lane_words = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        lane_words[l*WIDTH + k] = rxdin[k*LANES + l];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxdout     <= '0;
      all_locked <= 1'b0;
    end else begin
      rxdout     <= lane_words;
      all_locked <= retrain ? 1'b0 : &lane_locked;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lvds_lane_aligner #(
      .WIDTH         (WIDTH),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .MATCH_COUNT   (MATCH_COUNT),
      .SLIP_WAIT     (SLIP_WAIT),
      .MAX_SLIPS     (MAX_SLIPS)
    ) u_lane (
      .clk         (clk),
      .reset_n     (reset_n),
      .word        (lane_words[l*WIDTH +: WIDTH]),
      .train_en    (train_en),
      .retrain     (retrain),
      .bitslip     (bitslip[l]),
      .lane_locked (lane_locked[l]),
      .lane_err    (lane_err[l])
    );
  end

endmodule

// File: tb/tb_lvds_word_aligner.sv
// Bench for lvds_word_aligner: an ISERDES source that reacts to bitslip,
// a behavioural lane model, and a per-cycle compare process.
module tb_lvds_word_aligner;

  localparam int LANES       = 5;
  localparam int WIDTH       = 8;
  localparam int MATCH_COUNT = 8;
  localparam int SLIP_WAIT   = 4;
  localparam int MAX_SLIPS   = 2*WIDTH;
  localparam logic [WIDTH-1:0] TP = 8'h7E;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic train_en = 1'b0;
  logic retrain = 1'b0;
  logic [LANES*WIDTH-1:0] rxdin = '0;
  logic [LANES*WIDTH-1:0] rxdout;
  logic [LANES-1:0] bitslip, lane_locked, lane_err;
  logic all_locked;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lvds_word_aligner #(
    .LANES(LANES), .WIDTH(WIDTH), .TRAIN_PATTERN(TP),
    .MATCH_COUNT(MATCH_COUNT), .SLIP_WAIT(SLIP_WAIT), .MAX_SLIPS(MAX_SLIPS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rxdin(rxdin), .train_en(train_en),
    .retrain(retrain), .rxdout(rxdout), .bitslip(bitslip),
    .lane_locked(lane_locked), .lane_err(lane_err), .all_locked(all_locked)
  );

  // Source model: 0 = word rotated by mis[l] (each slip removes one bit of
  // rotation), 1 = fixed training word, 2 = constant cval[l].
  int mode [LANES];
  int mis [LANES];
  logic [WIDTH-1:0] cval [LANES];
  logic [WIDTH-1:0] cur_w [LANES];

  // Behavioural lane model (state after the next rising edge)
  bit m_active [LANES];
  bit m_pulse  [LANES];
  bit m_locked [LANES];
  bit m_err    [LANES];
  int m_match  [LANES];
  int m_slips  [LANES];
  int m_settle [LANES];
  logic [LANES*WIDTH-1:0] exp_rxdout = '0;
  bit exp_all = 1'b0;

  int cyc = 0;
  int pulses [LANES];
  int last_pulse [LANES];
  bit release_pending = 1'b0;
  logic [LANES-1:0] eb, el, ee;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] w, input int n);
    logic [WIDTH-1:0] r = w;
    for (int i = 0; i < n; i++) r = {r[WIDTH-2:0], r[WIDTH-1]};
    return r;
  endfunction

  task automatic lane_clear(input int l);
    m_active[l] = 0; m_pulse[l] = 0; m_locked[l] = 0; m_err[l] = 0;
    m_match[l] = 0; m_slips[l] = 0; m_settle[l] = 0;
  endtask

  task automatic model_step(input bit te, input bit rt);
    bit all = 1'b1;
    for (int l = 0; l < LANES; l++) all &= m_locked[l];
    exp_all = rt ? 1'b0 : all;
    for (int l = 0; l < LANES; l++) exp_rxdout[l*WIDTH +: WIDTH] = cur_w[l];
    for (int l = 0; l < LANES; l++) begin
      if (rt) lane_clear(l);
      else if (!m_active[l]) begin
        lane_clear(l);
        m_active[l] = te;
      end
      else if (m_locked[l] || m_err[l]) ;
      else if (m_pulse[l]) begin
        m_pulse[l] = 0;
        if (te) m_settle[l] = SLIP_WAIT;
        else lane_clear(l);
      end
      else if (!te) lane_clear(l);
      else if (m_settle[l] > 0) m_settle[l]--;
      else if (cur_w[l] == TP) begin
        m_match[l]++;
        if (m_match[l] == MATCH_COUNT) m_locked[l] = 1;
      end else begin
        m_match[l] = 0;
        if (m_slips[l] < MAX_SLIPS) begin m_pulse[l] = 1; m_slips[l]++; end
        else m_err[l] = 1;
      end
    end
  endtask

  task automatic drive_cycle(input bit te, input bit rt, input int corrupt_lane);
    @(negedge clk); #2;
    if (release_pending) begin reset_n = 1'b1; release_pending = 0; end
    for (int l = 0; l < LANES; l++)
      if (m_pulse[l] && mode[l] == 0) mis[l] = (mis[l] + WIDTH - 1) % WIDTH;
    for (int l = 0; l < LANES; l++) begin
      case (mode[l])
        0:       cur_w[l] = rotl(TP, mis[l]);
        1:       cur_w[l] = TP;
        default: cur_w[l] = cval[l];
      endcase
      if (l == corrupt_lane) cur_w[l] = ~cur_w[l];
      for (int k = 0; k < WIDTH; k++) rxdin[k*LANES + l] = cur_w[l][k];
    end
    train_en = te;
    retrain  = rt;
    if (rt || !te || !reset_n)
      for (int l = 0; l < LANES; l++) last_pulse[l] = -1;
    if (reset_n) model_step(te, rt);
  endtask

  task automatic run_until_all(input int budget, input int cstep, input int clane, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      drive_cycle(1'b1, 1'b0, (i == cstep) ? clane : -1);
      @(posedge clk); #1;
      if (all_locked) begin n = i; break; end
    end
    check("lock_reached", 64'(n != 0), 64'd1);
  endtask

  task automatic restart(input int m0, input int m1, input int m2, input int m3, input int m4);
    mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3; mode[4] = m4;
    drive_cycle(1'b0, 1'b1, -1);
    for (int l = 0; l < LANES; l++) pulses[l] = 0;
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    cyc++;
    for (int l = 0; l < LANES; l++) begin
      eb[l] = m_pulse[l]; el[l] = m_locked[l]; ee[l] = m_err[l];
    end
    check("rxdout", 64'(rxdout), 64'(exp_rxdout));
    check("bitslip", 64'(bitslip), 64'(eb));
    check("lane_locked", 64'(lane_locked), 64'(el));
    check("lane_err", 64'(lane_err), 64'(ee));
    check("all_locked", 64'(all_locked), 64'(exp_all));
    for (int l = 0; l < LANES; l++) begin
      if (bitslip[l]) begin
        if (last_pulse[l] >= 0)
          check("slip_spacing", 64'(cyc - last_pulse[l] >= SLIP_WAIT + 2), 64'd1);
        last_pulse[l] = cyc;
        pulses[l]++;
      end
    end
  end

  initial begin
    int n;
    int guard;
    int others;
    for (int l = 0; l < LANES; l++) begin
      mode[l] = 0; mis[l] = 0; cval[l] = '0; cur_w[l] = '0;
      pulses[l] = 0; last_pulse[l] = -1;
      lane_clear(l);
    end

    repeat (3) drive_cycle(1'b0, 1'b0, -1);
    @(posedge clk); #1;
    check("reset_outputs", 64'({rxdout, bitslip, lane_locked, lane_err, all_locked}), 64'd0);
    release_pending = 1;
    drive_cycle(1'b0, 1'b0, -1);

    // Aligned lanes: lock after 1 idle + 8 checks, all_locked one later
    run_until_all(50, -1, -1, n);
    check("aligned_latency", 64'(n), 64'd10);
    others = 0;
    for (int l = 0; l < LANES; l++) others += pulses[l];
    check("aligned_no_slips", 64'(others), 64'd0);

    // Retrain while locked
    drive_cycle(1'b1, 1'b1, -1);
    @(posedge clk); #1;
    check("retrain_clear", 64'({lane_locked, lane_err, bitslip, all_locked}), 64'd0);
    run_until_all(50, -1, -1, n);
    check("relock_latency", 64'(n), 64'd10);

    // Lane 2 rotated by 3 bits: 3 slips of 6 cycles each, then 8 matches
    mis[2] = 3;
    restart(0, 0, 0, 0, 0);
    run_until_all(100, -1, -1, n);
    check("rot3_latency", 64'(n), 64'd28);
    check("rot3_pulses", 64'(pulses[2]), 64'd3);
    others = pulses[0] + pulses[1] + pulses[3] + pulses[4];
    check("rot3_other_pulses", 64'(others), 64'd0);

    // One corrupted word after 5 matches on a fixed-pattern lane
    restart(0, 0, 1, 0, 0);
    run_until_all(100, 7, 2, n);
    check("corrupt_latency", 64'(n), 64'd21);
    check("corrupt_pulses", 64'(pulses[2]), 64'd1);

    // Lane 0 stuck at zero: slips exhausted, then error
    cval[0] = '0;
    restart(2, 0, 0, 0, 0);
    repeat (120) drive_cycle(1'b1, 1'b0, -1);
    @(posedge clk); #1;
    check("stuck_pulses", 64'(pulses[0]), 64'd16);
    check("stuck_err", 64'(lane_err[0]), 64'd1);
    check("stuck_locked", 64'(lane_locked[0]), 64'd0);
    check("stuck_all_locked", 64'(all_locked), 64'd0);

    // Asynchronous reset while lane 2 waits after a slip
    mis[2] = 5;
    restart(0, 0, 0, 0, 0);
    guard = 0;
    do begin
      drive_cycle(1'b1, 1'b0, -1);
      guard++;
    end while (!(m_settle[2] > 0 && m_locked[0]) && guard < 100);
    check("reached_wait", 64'(guard < 100), 64'd1);
    @(posedge clk); #2;
    check("pre_reset_locked0", 64'(lane_locked[0]), 64'd1);
    reset_n = 1'b0;
    for (int l = 0; l < LANES; l++) lane_clear(l);
    exp_rxdout = '0;
    exp_all = 1'b0;
    #1;
    check("async_reset_outputs", 64'({rxdout, bitslip, lane_locked, lane_err, all_locked}), 64'd0);
    repeat (2) drive_cycle(1'b1, 1'b0, -1);
    release_pending = 1;
    run_until_all(200, -1, -1, n);

    // Randomised traffic: offsets, dropouts, retrains, corruptions
    for (int t = 0; t < 4; t++) begin
      for (int l = 0; l < LANES; l++) begin
        mis[l] = $urandom_range(0, WIDTH - 1);
        cval[l] = WIDTH'($urandom);
      end
      restart(($urandom_range(0, 7) == 0) ? 2 : 0, 0, ($urandom_range(0, 3) == 0) ? 1 : 0, 0, 0);
      for (int i = 0; i < 300; i++) begin
        bit te;
        bit rt;
        int cl;
        te = ($urandom_range(0, 49) != 0);
        rt = ($urandom_range(0, 79) == 0);
        cl = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, LANES - 1)) : -1;
        drive_cycle(te, rt, cl);
      end
    end

    @(negedge clk); #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lvds_word_aligner.md
LVDS_WORD_ALIGNER -- requirements
Module: lvds_word_aligner

Interface
REQ-001 SHALL have parameter LANES, default 5, meaning number of serial lanes.
REQ-002 SHALL have parameter WIDTH, default 8, meaning deserialisation factor (bits per lane word).
REQ-003 SHALL have parameter TRAIN_PATTERN, WIDTH bits, default 8'h7E, meaning training word.
REQ-004 SHALL have parameter MATCH_COUNT, default 8, meaning consecutive matches required for lock.
REQ-005 SHALL have parameter SLIP_WAIT, default 4, meaning settle cycles after each bitslip pulse.
REQ-006 SHALL have parameter MAX_SLIPS, default 2*WIDTH, meaning slips allowed before lane error.
REQ-007 clk  input  1  sole clock; all logic on rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 rxdin  input  LANES*WIDTH  bit-interleaved ISERDES output; lane l bit k at index k*LANES+l.
REQ-010 train_en  input  1  enables alignment.
REQ-011 retrain  input  1  single-cycle pulse; restarts alignment on all lanes.
REQ-012 rxdout  output  LANES*WIDTH  lane-grouped registered data; lane l at [l*WIDTH +: WIDTH].
REQ-013 bitslip  output  LANES  per-lane single-cycle bitslip pulse to ISERDES.
REQ-014 lane_locked  output  LANES  per-lane lock status.
REQ-015 lane_err  output  LANES  per-lane alignment failure.
REQ-016 all_locked  output  1  registered AND of lane_locked.

Function
REQ-017 rxdout SHALL equal the de-interleaved rxdin, registered once (latency 1 cycle).
REQ-018 Each lane SHALL run an independent FSM: IDLE, CHECK, SLIP, WAIT, LOCKED, ERR.
REQ-019 IDLE -> CHECK when train_en=1; all lane counters zero in IDLE.
REQ-020 CHECK: lane word == TRAIN_PATTERN increments match_cnt; LOCKED when the MATCH_COUNT-th consecutive match is seen.
REQ-021 CHECK: mismatch clears match_cnt; -> SLIP if slip_cnt < MAX_SLIPS, else -> ERR.
REQ-022 SLIP: bitslip[l]=1 for exactly one cycle, slip_cnt increments, -> WAIT.
REQ-023 WAIT: hold SLIP_WAIT cycles (bitslip=0), then -> CHECK; comparisons in WAIT are ignored.
REQ-024 LOCKED: lane_locked=1; remains until retrain or reset, independent of train_en and data.
REQ-025 ERR: lane_err=1; remains until retrain or reset.
REQ-026 train_en=0 in CHECK or WAIT SHALL return lane to IDLE next cycle; in SLIP the pulse completes, then IDLE.
REQ-027 retrain=1 SHALL force every lane to IDLE next cycle, clearing lane_locked, lane_err, counters; retrain has priority over all other transitions.
REQ-028 Minimum spacing between bitslip pulses on a lane SHALL be SLIP_WAIT+2 cycles.
REQ-029 all_locked SHALL assert one cycle after the last lane_locked rises.
REQ-030 Counter widths SHALL be $clog2 of their maximum+1; no counter wraps.

Reset
REQ-031 reset_n low SHALL asynchronously clear rxdout, bitslip, lane_locked, lane_err, all_locked to 0, FSMs to IDLE, counters to 0.
REQ-032 Reset deassertion mid-training SHALL restart from IDLE; no bitslip pulse in the first cycle after release.

Structure
REQ-033 Lane FSM state encoding and default TRAIN_PATTERN SHALL live in shared package lvds_align_pkg.
REQ-034 Per-lane logic SHALL be sub-module lvds_lane_aligner, instantiated LANES times via generate.

Verification
REQ-035 Aligned pattern 8'h7E on all 5 lanes, train_en=1 -> no bitslip; all lanes locked after 8 checks; all_locked one cycle later.
REQ-036 Lane 2 rotated by 3 bits (model slips) -> exactly 3 bitslip[2] pulses, spaced >=6 cycles; lane 2 locks; other lanes zero slips.
REQ-037 Lane 0 constant 8'h00 -> 16 pulses, then lane_err[0]=1, lane_locked[0]=0, all_locked=0.
REQ-038 Single corrupted word after 5 matches -> match_cnt restarts, one bitslip, lock still reached.
REQ-039 retrain pulse while all locked -> all outputs 0 next cycle, re-lock sequence repeats.
REQ-040 reset_n asserted mid-WAIT -> outputs 0 immediately (no clock edge), restart from IDLE after release.
